spi_slave_if: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0) responder. It is the far end of the team's joystick-style SPI master, so a FPGA-side PMOD emulator and loopback benches can answer 40-bit frames.
- Runs entirely on the 50 MHz system clock and oversamples the external sck, cs and mosi through synchronizers; it has no logic clocked by sck.
- Delivers each received frame to user logic with a valid pulse and shifts out a frame captured from user logic at chip-select assertion.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_pin_sync.sv | 32 +++
 rtl/spi_slave_if.sv | 125 ++++++++++++
 tb/tb_spi_slave_if.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the mode-0 SPI responder: frame geometry,
// synchronizer depth and FSM state encoding.
package spi_pkg;

  localparam int FRAME_BITS_DEFAULT  = 40;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one external pin, with single-cycle
// rise/fall pulses taken from the last stage against a delayed copy.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder running purely on clk; sck, cs and mosi are
// oversampled, so no logic is clocked by sck.
//
//   state  | meaning
//   IDLE   | deselected, miso tristated, sck ignored
//   ACTIVE | selected, shifting bits in on sck rise and out on sck fall
//   DONE   | full frame delivered; extra sck rises flag an overrun
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [FRAME_BITS-1:0] tx_bytes,
  output logic [FRAME_BITS-1:0] rx_bytes,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int             CW       = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FRAME_BITS);

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(sck), .q_o(), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(cs), .q_o(), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s), .rise_o(), .fall_o()
  );

  spi_state_e            state_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovr_q;
  logic [FRAME_BITS-1:0] tx_sr_q, rx_sr_q, rx_d, rx_bytes_q;
  logic                  miso_q, miso_oe_q, busy_q, rx_valid_q, frame_err_q;

  assign cnt_d = cnt_q + CW'(1);
  assign rx_d  = {rx_sr_q[FRAME_BITS-2:0], mosi_s};

  // cs detections are tested first so a coincident sck edge is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_bytes_q  <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            tx_sr_q   <= tx_bytes;
            rx_sr_q   <= '0;
            miso_q    <= tx_bytes[FRAME_BITS-1];
            miso_oe_q <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (sck_rise) begin
            rx_sr_q <= rx_d;
            cnt_q   <= cnt_d;
            if (cnt_d == CNT_FULL) begin
              rx_bytes_q <= rx_d;
              rx_valid_q <= 1'b1;
              state_q    <= DONE;
            end
          end else if (sck_fall && cnt_q != '0) begin
            tx_sr_q <= {tx_sr_q[FRAME_BITS-2:0], 1'b0};
            miso_q  <= tx_sr_q[FRAME_BITS-2];
          end
        end
        DONE: begin
          if (cs_rise) begin
            frame_err_q <= ovr_q;
            ovr_q       <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (sck_rise) begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign busy      = busy_q;
  assign rx_bytes  = rx_bytes_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: a bit-banged mode-0 master with a
// scoreboard of expected received frames popped on every rx_valid.
module tb_spi_slave_if;

  localparam int FB = 40;
  localparam int SS = 2;
  localparam int H  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sck = 1'b0;
  logic          cs = 1'b1;
  logic          mosi = 1'b0;
  logic [FB-1:0] tx_bytes = '0;
  logic          miso, miso_oe, rx_valid, frame_err, busy;
  logic [FB-1:0] rx_bytes;

  always #10 clk = ~clk;

  spi_slave_if #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_bytes(tx_bytes),
    .rx_bytes(rx_bytes), .rx_valid(rx_valid), .frame_err(frame_err),
    .busy(busy)
  );

  int            vectors = 0;
  int            miscompares = 0;
  int            rv_cnt = 0;
  int            fe_cnt = 0;
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] mon_exp;
  logic [3:0]    cs_hist = 4'hF;
  logic [3:0]    rst_hist = 4'hF;

  // Scoreboard pop and continuous pin-level invariants.
  always @(negedge clk) begin
    cs_hist  <= {cs_hist[2:0], cs};
    rst_hist <= {rst_hist[2:0], rst};
    if (rx_valid) begin
      rv_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_valid_unexpected: rx_bytes=%h, no frame pending", rx_bytes);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_bytes !== mon_exp) begin
          miscompares++;
          $display("FAIL rx_data: got %h, expected %h", rx_bytes, mon_exp);
        end
      end
    end
    if (frame_err) fe_cnt++;
    if (rx_valid || frame_err) begin
      vectors++;
      if (rx_valid && frame_err) begin
        miscompares++;
        $display("FAIL valid_err_overlap: rx_valid=%b frame_err=%b, expected not both", rx_valid, frame_err);
      end
    end
    if (rst_hist == 4'h0 && !rst && cs_hist == {4{cs}}) begin
      vectors++;
      if (miso_oe !== ~cs || busy !== ~cs) begin
        miscompares++;
        $display("FAIL oe_busy_vs_cs: cs=%b miso_oe=%b busy=%b, expected oe=busy=%b", cs, miso_oe, busy, ~cs);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic sck_pulse(input logic b, output logic m);
    mosi = b;
    wait_clk(H);
    sck = 1'b1;
    m = miso;
    wait_clk(H);
    sck = 1'b0;
  endtask

  task automatic run_frame(input logic [FB-1:0] d, input int nbits, input int gap,
                           output logic [FB-1:0] cap);
    logic m;
    cap = '0;
    if (nbits >= FB) exp_q.push_back(d);
    cs = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      sck_pulse((i < FB) ? d[FB-1-i] : 1'b0, m);
      if (i < FB) cap[FB-1-i] = m;
    end
    wait_clk(H);
    cs = 1'b1;
    if (gap >= SS + 1) begin
      wait_clk(SS + 1);
      vectors++;
      if (busy !== 1'b0 || miso_oe !== 1'b0) begin
        miscompares++;
        $display("FAIL cs_rise_release: busy=%b miso_oe=%b, expected 0 0", busy, miso_oe);
      end
      wait_clk(gap - SS - 1);
    end else begin
      wait_clk(gap);
    end
  endtask

  task automatic test_reset();
    wait_clk(2);
    vectors++;
    if ({miso, miso_oe, rx_bytes, rx_valid, frame_err, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: miso=%b oe=%b rx=%h rv=%b fe=%b busy=%b, expected all 0",
               miso, miso_oe, rx_bytes, rx_valid, frame_err, busy);
    end
    rst = 1'b0;
    wait_clk(6);
    vectors++;
    if ({miso_oe, rx_valid, frame_err, busy} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: oe=%b rv=%b fe=%b busy=%b, expected 0", miso_oe, rx_valid, frame_err, busy);
    end
  endtask

  task automatic test_full_frame();
    logic [FB-1:0] cap;
    int rv0 = rv_cnt, fe0 = fe_cnt;
    tx_bytes = 40'hA5_0123_4567;
    run_frame(40'hDE_ADBE_EF01, FB, H, cap);
    vectors += 4;
    if (cap !== 40'hA5_0123_4567) begin
      miscompares++; $display("FAIL full_miso: master got %h, expected %h", cap, 40'hA5_0123_4567);
    end
    if (rx_bytes !== 40'hDE_ADBE_EF01) begin
      miscompares++; $display("FAIL full_rx: got %h, expected %h", rx_bytes, 40'hDE_ADBE_EF01);
    end
    if (rv_cnt - rv0 != 1 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL full_rv_count: %0d pulses, expected 1", rv_cnt - rv0);
    end
    if (fe_cnt != fe0) begin
      miscompares++; $display("FAIL full_frame_err: %0d pulses, expected 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_abort();
    logic [FB-1:0] cap;
    int rv0 = rv_cnt, fe0 = fe_cnt;
    tx_bytes = 40'h11_2233_4455;
    run_frame(40'h55_AA55_AA55, 17, H, cap);
    vectors += 3;
    if (fe_cnt - fe0 != 1) begin
      miscompares++; $display("FAIL abort_frame_err: %0d pulses, expected 1", fe_cnt - fe0);
    end
    if (rv_cnt != rv0) begin
      miscompares++; $display("FAIL abort_rv: %0d pulses, expected 0", rv_cnt - rv0);
    end
    if (rx_bytes !== 40'hDE_ADBE_EF01) begin
      miscompares++; $display("FAIL abort_rx_hold: got %h, expected %h", rx_bytes, 40'hDE_ADBE_EF01);
    end
  endtask

  task automatic test_overrun();
    logic [FB-1:0] cap;
    int rv0 = rv_cnt, fe0 = fe_cnt;
    tx_bytes = 40'h0F_0F0F_0F0F;
    run_frame(40'h12_3456_789A, FB + 1, H, cap);
    vectors += 4;
    if (rv_cnt - rv0 != 1 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL ovr_rv_count: %0d pulses, expected 1", rv_cnt - rv0);
    end
    if (fe_cnt - fe0 != 1) begin
      miscompares++; $display("FAIL ovr_frame_err: %0d pulses, expected 1", fe_cnt - fe0);
    end
    if (rx_bytes !== 40'h12_3456_789A) begin
      miscompares++; $display("FAIL ovr_rx: got %h, expected %h", rx_bytes, 40'h12_3456_789A);
    end
    if (cap !== 40'h0F_0F0F_0F0F) begin
      miscompares++; $display("FAIL ovr_miso: master got %h, expected %h", cap, 40'h0F_0F0F_0F0F);
    end
  endtask

  task automatic test_msb_present();
    logic m;
    int rv0 = rv_cnt;
    tx_bytes = 40'h80_0000_0000;
    exp_q.push_back('0);
    cs = 1'b0;
    wait_clk(SS + 1);
    vectors++;
    if (miso !== 1'b1 || miso_oe !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL msb_at_select: miso=%b oe=%b busy=%b, expected 1 1 1", miso, miso_oe, busy);
    end
    sck_pulse(1'b0, m);
    vectors++;
    if (m !== 1'b1) begin
      miscompares++; $display("FAIL msb_first_rise: master got %b, expected 1", m);
    end
    wait_clk(SS + 1);
    vectors++;
    if (miso !== 1'b0) begin
      miscompares++; $display("FAIL msb_after_fall: miso=%b, expected 0", miso);
    end
    for (int i = 1; i < FB; i++) sck_pulse(1'b0, m);
    wait_clk(H);
    cs = 1'b1;
    wait_clk(H);
    vectors++;
    if (rv_cnt - rv0 != 1 || rx_bytes !== '0) begin
      miscompares++; $display("FAIL msb_rx: %0d pulses rx=%h, expected 1 pulse rx=0", rv_cnt - rv0, rx_bytes);
    end
  endtask

  task automatic test_reset_midframe();
    logic m;
    logic [FB-1:0] cap;
    int rv0, fe0;
    tx_bytes = 40'hC3_C3C3_C3C3;
    cs = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 20; i++) sck_pulse(1'b1, m);
    rst = 1'b1;
    #1;
    vectors++;
    if ({miso, miso_oe, rx_bytes, rx_valid, frame_err, busy} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: miso=%b oe=%b rx=%h rv=%b fe=%b busy=%b, expected all 0",
               miso, miso_oe, rx_bytes, rx_valid, frame_err, busy);
    end
    cs = 1'b1;
    mosi = 1'b0;
    wait_clk(4);
    vectors++;
    if ({miso, miso_oe, rx_bytes, rx_valid, frame_err, busy} !== '0) begin
      miscompares++; $display("FAIL rst_hold_outputs: rx=%h oe=%b busy=%b, expected 0", rx_bytes, miso_oe, busy);
    end
    rst = 1'b0;
    wait_clk(8);
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    run_frame('1, FB, H, cap);
    vectors += 2;
    if (rx_bytes !== 40'hFF_FFFF_FFFF || rv_cnt - rv0 != 1) begin
      miscompares++; $display("FAIL rst_next_frame: rx=%h pulses=%0d, expected ffffffffff 1", rx_bytes, rv_cnt - rv0);
    end
    if (fe_cnt != fe0) begin
      miscompares++; $display("FAIL rst_spurious_err: %0d pulses, expected 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] cap;
    int rv0 = rv_cnt, fe0 = fe_cnt;
    tx_bytes = 40'h00_0000_00F0;
    run_frame(40'h1, FB, 2, cap);
    tx_bytes = 40'h00_0000_000F;
    run_frame(40'h2, FB, H, cap);
    vectors += 3;
    if (rv_cnt - rv0 != 2 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL b2b_rv_count: %0d pulses, expected 2", rv_cnt - rv0);
    end
    if (rx_bytes !== 40'h2 || fe_cnt != fe0) begin
      miscompares++; $display("FAIL b2b_final: rx=%h fe=%0d, expected 2 and 0", rx_bytes, fe_cnt - fe0);
    end
    if (cap !== 40'h00_0000_000F) begin
      miscompares++; $display("FAIL b2b_miso: master got %h, expected %h", cap, 40'h0F);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_abort();
    test_overrun();
    test_msb_present();
    test_reset_midframe();
    test_back_to_back();
    wait_clk(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
